// File: rtl/icache_ctrl_if.sv
// rtl/icache_ctrl_if.sv - IFU, cache-array and memory-bus interfaces for icache_ctrl
// The controller uses the slave side of the IFU port and the master side of the cache and memory ports.

interface icache_ifu_if;
  logic        ifu_reqValid;
  logic [29:0] ifu_addr;
  logic        ifu_reqReady;
  logic        ifu_respValid;
  logic        ifu_respReady;
  logic [31:0] ifu_rdata;
  logic        ifu_err;

  modport master (
    output ifu_reqValid, ifu_addr, ifu_respReady,
    input  ifu_reqReady, ifu_respValid, ifu_rdata, ifu_err
  );
  modport slave (
    input  ifu_reqValid, ifu_addr, ifu_respReady,
    output ifu_reqReady, ifu_respValid, ifu_rdata, ifu_err
  );
endinterface

interface icache_cache_if;
  logic        c_reqValid;
  logic        c_wen;
  logic [29:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_is_hit;
  logic [31:0] c_rdata;
  logic        c_respValid;

  modport master (
    output c_reqValid, c_wen, c_addr, c_wdata,
    input  c_is_hit, c_rdata, c_respValid
  );
  modport slave (
    input  c_reqValid, c_wen, c_addr, c_wdata,
    output c_is_hit, c_rdata, c_respValid
  );
endinterface

interface icache_mem_if;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;

  modport master (
    output mem_arvalid, mem_araddr, mem_rready,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rresp
  );
  modport slave (
    input  mem_arvalid, mem_araddr, mem_rready,
    output mem_arready, mem_rvalid, mem_rdata, mem_rresp
  );
endinterface

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - instruction-cache controller: lookup, single-word miss fill, memory watchdog
// Optional hit/miss counters are built when ICACHE_CTRL_PERF_EN is defined.

module icache_ctrl #(
  parameter int TIMEOUT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  icache_ifu_if.slave        ifu,
  icache_cache_if.master     cache,
  icache_mem_if.master       mem,
  output logic [31:0]        perf_hits,
  output logic [31:0]        perf_misses
);

  typedef enum logic [2:0] {IDLE, LOOKUP, AR, R, FILL, RESP} state_t;

  // The check happens one count early so the abandon lands on the cycle the counter reaches all-ones.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state, state_nxt;
  logic [29:0]          addr_q, addr_nxt;
  logic [31:0]          data_q, data_nxt;
  logic                 err_q, err_nxt;
  logic [TIMEOUT_W-1:0] to_cnt, to_cnt_nxt;
  logic                 to_expire;
  logic                 unused_resp;

  assign to_expire   = (to_cnt == TO_LAST);
  assign unused_resp = cache.c_respValid;

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    data_nxt   = data_q;
    err_nxt    = err_q;
    to_cnt_nxt = to_cnt;
    case (state)
      IDLE: begin
        if (ifu.ifu_reqValid) begin
          addr_nxt  = ifu.ifu_addr;
          err_nxt   = 1'b0;
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cache.c_is_hit) begin
          data_nxt  = cache.c_rdata;
          err_nxt   = 1'b0;
          state_nxt = RESP;
        end else begin
          to_cnt_nxt = '0;
          state_nxt  = AR;
        end
      end
      AR: begin
        to_cnt_nxt = to_cnt + 1'b1;
        if (mem.mem_arready) begin
          state_nxt = R;
        end else if (to_expire) begin
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end
      end
      R: begin
        to_cnt_nxt = to_cnt + 1'b1;
        if (mem.mem_rvalid) begin
          data_nxt = mem.mem_rdata;
          if (mem.mem_rresp == 2'b00) begin
            state_nxt = FILL;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = RESP;
          end
        end else if (to_expire) begin
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end
      end
      FILL: state_nxt = RESP;
      RESP: begin
        if (ifu.ifu_respReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      addr_q              <= '0;
      data_q              <= '0;
      err_q               <= 1'b0;
      to_cnt              <= '0;
      ifu.ifu_reqReady    <= 1'b1;
      ifu.ifu_respValid   <= 1'b0;
      ifu.ifu_rdata       <= '0;
      ifu.ifu_err         <= 1'b0;
      cache.c_reqValid    <= 1'b0;
      cache.c_wen         <= 1'b0;
      cache.c_addr        <= '0;
      cache.c_wdata       <= '0;
      mem.mem_arvalid     <= 1'b0;
      mem.mem_araddr      <= '0;
      mem.mem_rready      <= 1'b0;
    end else begin
      state               <= state_nxt;
      addr_q              <= addr_nxt;
      data_q              <= data_nxt;
      err_q               <= err_nxt;
      to_cnt              <= to_cnt_nxt;
      ifu.ifu_reqReady    <= (state_nxt == IDLE);
      ifu.ifu_respValid   <= (state_nxt == RESP);
      ifu.ifu_rdata       <= (state_nxt == RESP) ? data_nxt : '0;
      ifu.ifu_err         <= (state_nxt == RESP) && err_nxt;
      cache.c_reqValid    <= (state_nxt == LOOKUP);
      cache.c_wen         <= (state_nxt == FILL);
      cache.c_addr        <= (state_nxt == LOOKUP || state_nxt == FILL) ? addr_nxt : '0;
      cache.c_wdata       <= (state_nxt == FILL) ? data_nxt : '0;
      mem.mem_arvalid     <= (state_nxt == AR);
      mem.mem_araddr      <= (state_nxt == AR) ? {addr_nxt, 2'b00} : '0;
      // Ready in IDLE drains late data from an abandoned read.
      mem.mem_rready      <= (state_nxt == R) || (state_nxt == IDLE);
    end
  end

`ifdef ICACHE_CTRL_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if (state == LOOKUP) begin
      if (cache.c_is_hit) begin
        if (perf_hits != 32'hFFFF_FFFF) perf_hits <= perf_hits + 32'd1;
      end else begin
        if (perf_misses != 32'hFFFF_FFFF) perf_misses <= perf_misses + 32'd1;
      end
    end
  end
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - scoreboard bench for icache_ctrl with cache and memory models
// Built with TIMEOUT_W=4; perf expectations follow ICACHE_CTRL_PERF_EN.

module tb_icache_ctrl;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

`ifdef ICACHE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] perf_hits, perf_misses;

  icache_ifu_if   ifu ();
  icache_cache_if ca ();
  icache_mem_if   mem ();

  icache_ctrl #(.TIMEOUT_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .ifu         (ifu),
    .cache       (ca),
    .mem         (mem),
    .perf_hits   (perf_hits),
    .perf_misses (perf_misses)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb [$];
  int   hits_exp = 0;
  int   miss_exp = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Direct-mapped 16-entry cache array model.
  bit          cv   [16];
  logic [25:0] ctag [16];
  logic [31:0] cdat [16];
  wire  [3:0]  cidx = ca.c_addr[3:0];

  assign ca.c_is_hit    = ca.c_reqValid && !ca.c_wen && cv[cidx] && (ctag[cidx] == ca.c_addr[29:4]);
  assign ca.c_rdata     = cdat[cidx];
  assign ca.c_respValid = ca.c_reqValid;

  always @(posedge clock) begin
    if (ca.c_wen) begin
      cv[cidx]   <= 1'b1;
      ctag[cidx] <= ca.c_addr[29:4];
      cdat[cidx] <= ca.c_wdata;
    end
  end

  int          wen_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic [29:0] last_waddr = '0;

  always @(negedge clock) begin
    if (ca.c_wen) begin
      wen_cnt    <= wen_cnt + 1;
      last_wdata <= ca.c_wdata;
      last_waddr <= ca.c_addr;
    end
  end

  // Memory slave: arready held high, data one cycle after the address handshake.
  int          mem_mode = 0;
  logic [31:0] mem_rd = '0;
  int          stray_req = 0;
  int          stray_done = 0;
  logic        stray_rready = 1'b0;
  int          ar_cnt = 0;
  logic [31:0] last_araddr = '0;
  int          last_ar_cyc = 0;
  bit          pend = 1'b0;

  initial begin
    mem.mem_arready = 1'b1;
    mem.mem_rvalid  = 1'b0;
    mem.mem_rdata   = '0;
    mem.mem_rresp   = 2'b00;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend           = 1'b0;
        mem.mem_rvalid = 1'b0;
      end else begin
        if (ifu.ifu_reqReady) pend = 1'b0;
        if (mem.mem_rvalid) begin
          mem.mem_rvalid = 1'b0;
        end else if (stray_done != stray_req) begin
          stray_done++;
          stray_rready   = mem.mem_rready;
          mem.mem_rvalid = 1'b1;
          mem.mem_rdata  = 32'hDEAD_BEEF;
          mem.mem_rresp  = 2'b00;
        end else if (pend && mem.mem_rready && mem_mode != 2) begin
          mem.mem_rvalid = 1'b1;
          mem.mem_rdata  = mem_rd;
          mem.mem_rresp  = (mem_mode == 1) ? 2'b10 : 2'b00;
          pend           = 1'b0;
        end
        if (mem.mem_arvalid && mem.mem_arready) begin
          pend        = 1'b1;
          ar_cnt++;
          last_araddr = mem.mem_araddr;
          last_ar_cyc = cyc;
        end
      end
    end
  end

  function automatic logic others_or();
    return |{ifu.ifu_respValid, ifu.ifu_rdata, ifu.ifu_err, ca.c_reqValid, ca.c_wen,
             ca.c_addr, ca.c_wdata, mem.mem_arvalid, mem.mem_araddr, mem.mem_rready,
             perf_hits, perf_misses};
  endfunction

  task automatic check_perf(input string tag);
    check_eq({tag, "_hits"},   perf_hits,   PERF ? hits_exp : 0);
    check_eq({tag, "_misses"}, perf_misses, PERF ? miss_exp : 0);
  endtask

  // mode: 0 good read, 1 error response, 2 silent memory (watchdog)
  task automatic fetch(input logic [29:0] a, input int mode, input logic [31:0] rd,
                       input bit hit, input logic [31:0] exp_data, input int hold);
    exp_t        e;
    int          c0, ar0, wen0;
    bit          got, stable;
    logic [31:0] held;
    e.err  = !hit && (mode != 0);
    e.data = exp_data;
    e.lat  = hit ? 2 : (mode == 0) ? 5 : (mode == 1) ? 4 : 17;
    sb.push_back(e);
    if (hit) hits_exp++; else miss_exp++;
    mem_mode = mode;
    mem_rd   = rd;
    ar0      = ar_cnt;
    wen0     = wen_cnt;
    @(negedge clock);
    check_eq("req_ready", ifu.ifu_reqReady, 1'b1);
    ifu.ifu_reqValid = 1'b1;
    ifu.ifu_addr     = a;
    c0               = cyc;
    @(posedge clock);
    #1 ifu.ifu_reqValid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (ifu.ifu_respValid) got = 1'b1;
    end
    e = sb.pop_front();
    if (!got) begin
      check_eq("resp_timeout", got, 1'b1);
      return;
    end
    check_eq("latency", cyc - c0, e.lat);
    check_eq("err", ifu.ifu_err, e.err);
    if (!e.err) check_eq("rdata", ifu.ifu_rdata, e.data);
    if (hit) begin
      check_eq("no_ar_on_hit", ar_cnt - ar0, 0);
    end else begin
      check_eq("ar_count", ar_cnt - ar0, 1);
      check_eq("araddr", last_araddr, {a, 2'b00});
      if (mode == 2) check_eq("ar_cycle", last_ar_cyc - c0, 2);
    end
    check_eq("fills", wen_cnt - wen0, (!hit && mode == 0) ? 1 : 0);
    if (!hit && mode == 0) begin
      check_eq("fill_wdata", last_wdata, rd);
      check_eq("fill_addr", last_waddr, a);
    end
    held   = ifu.ifu_rdata;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clock);
      if (ifu.ifu_rdata !== held || !ifu.ifu_respValid || ifu.ifu_reqReady) stable = 1'b0;
    end
    if (hold > 0) check_eq("hold_stable", stable, 1'b1);
    ifu.ifu_respReady = 1'b1;
    @(posedge clock);
    #1 ifu.ifu_respReady = 1'b0;
    @(negedge clock);
    check_eq("back_idle", {ifu.ifu_reqReady, ifu.ifu_respValid}, 2'b10);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit got;
    ifu.ifu_reqValid  = 1'b0;
    ifu.ifu_addr      = '0;
    ifu.ifu_respReady = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst_req_ready", ifu.ifu_reqReady, 1'b1);
    check_eq("rst_outputs", others_or(), 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("idle_rready", mem.mem_rready, 1'b1);

    fetch(30'h0800_0000, 0, 32'h0000_0013, 1'b0, 32'h0000_0013, 0);
    fetch(30'h0800_0000, 0, 32'h0,         1'b1, 32'h0000_0013, 0);
    check_perf("perf_a");
    fetch(30'h0000_0041, 1, 32'h1111_2222, 1'b0, 32'h0,         0);
    fetch(30'h0000_1234, 2, 32'h0,         1'b0, 32'h0,         0);

    stray_req++;
    repeat (3) @(negedge clock);
    check_eq("stray_rready", stray_rready, 1'b1);

    fetch(30'h0000_0107, 0, 32'h1234_5678, 1'b0, 32'h1234_5678, 10);
    fetch(30'h0000_0107, 0, 32'h0,         1'b1, 32'h1234_5678, 0);
    fetch(30'h0000_0041, 0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 0);
    check_perf("perf_b");

    // Reset while waiting on a read that never returns.
    mem_mode = 2;
    @(negedge clock);
    ifu.ifu_reqValid = 1'b1;
    ifu.ifu_addr     = 30'h0000_0222;
    @(posedge clock);
    #1 ifu.ifu_reqValid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (mem.mem_rready && !ifu.ifu_reqReady) got = 1'b1;
    end
    check_eq("reach_r", got, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("midrst_req_ready", ifu.ifu_reqReady, 1'b1);
    check_eq("midrst_outputs", others_or(), 1'b0);
    hits_exp = 0;
    miss_exp = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    fetch(30'h0800_0000, 0, 32'h0, 1'b1, 32'h0000_0013, 0);
    check_perf("perf_c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
